// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment definitions; patterns are logical (1 = lit), bit order {g,f,e,d,c,b,a}.
package seg_pkg;
   typedef enum int {SEG_A = 0, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G} seg_bit_t;
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/seg_digit_decoder.sv
// seg_digit_decoder: 4-bit code to logical segment pattern; non-BCD codes show a dash.
module seg_digit_decoder
   import seg_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_DASH;
      case (code)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit display scan with shadow register,
// leading-zero blanking and registered, polarity-selectable outputs.
module seven_seg_scan_driver
   import seg_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] BCD_IN,
   input  logic [N_DIGITS-1:0]   DP_IN,
   input  logic                  LOAD,
   input  logic                  BLANK_LZ,
   input  logic                  ENABLE,
   output logic [6:0]            SEG,
   output logic                  DP,
   output logic [N_DIGITS-1:0]   AN,
   output logic                  FRAME_START
);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
   logic [PW-1:0]         presc;
   logic [IW-1:0]         idx;
   logic [4*N_DIGITS-1:0] sh_bcd, cur_bcd;
   logic [N_DIGITS-1:0]   sh_dp, cur_dp, blank, cur_blank, an_l;
   logic [3:0]            code;
   logic [6:0]            glyph, seg_l;
   logic                  tc, wrap, run, off, dp_l;
   assign tc        = presc == PW'(REFRESH_DIV - 1);
   assign wrap      = tc && idx == IW'(N_DIGITS - 1);
   assign cur_bcd   = sh_bcd >> (4 * idx);
   assign cur_dp    = sh_dp >> idx;
   assign cur_blank = blank >> idx;
   assign code      = cur_bcd[3:0];
   // Blank runs down from the top digit while digits are zero without a DP; digit 0 never blanks.
   always_comb begin
      blank = '0;
      run   = 1'b1;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
         run      = run & (sh_bcd[4*i +: 4] == 4'd0) & ~sh_dp[i];
         blank[i] = BLANK_LZ & run;
      end
   end
   seg_digit_decoder u_dec (.code(code), .seg(glyph));
   assign off   = cur_blank[0] | ~ENABLE;
   assign seg_l = off ? SEG_BLANK : glyph;
   assign dp_l  = ~off & cur_dp[0];
   assign an_l  = ENABLE ? N_DIGITS'(1) << idx : '0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc       <= '0;
         idx         <= '0;
         sh_bcd      <= '0;
         sh_dp       <= '0;
         FRAME_START <= 1'b0;
         SEG         <= {7{ACTIVE_LOW}};
         DP          <= ACTIVE_LOW;
         AN          <= {N_DIGITS{ACTIVE_LOW}};
      end else begin
         presc <= tc ? '0 : presc + 1'b1;
         if (tc) idx <= wrap ? '0 : idx + 1'b1;
         if (LOAD) begin
            sh_bcd <= BCD_IN;
            sh_dp  <= DP_IN;
         end
         FRAME_START <= wrap;
         SEG         <= seg_l ^ {7{ACTIVE_LOW}};
         DP          <= dp_l ^ ACTIVE_LOW;
         AN          <= an_l ^ {N_DIGITS{ACTIVE_LOW}};
      end
   end
endmodule
